// File: rtl/csa_chunked_adder_if.sv
// Operand/result bus for csa_chunked_adder: valid/ready on the operand side and on the result side.
// The master drives operands and accepts results; the slave is the adder.
interface csa_chunked_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [1:0]       carry_out;
  logic             busy;

  modport master (
    output in_valid, mode, acc_clr, a, b, c, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );

  modport slave (
    input  in_valid, mode, acc_clr, a, b, c, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
endinterface

// File: rtl/csa_chunked_adder.sv
// Three-operand carry-save adder whose carry-propagate stage resolves CHUNK bits per cycle.
// Optional accumulate mode feeds the previous WIDTH-bit result back as the third operand.
module csa_chunked_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_chunked_adder_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_chunked_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH:0]   c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [1:0]       carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] op3;
  logic [WIDTH-1:0] fa_s;
  logic [WIDTH-1:0] fa_c;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK-1:0] c_chunk;
  logic [CHUNK:0]   chunk_res;

  // A same-cycle acc_clr must already be visible to an accumulate-mode accept.
  assign op3 = bus.mode ? (bus.acc_clr ? '0 : acc_q) : bus.c;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign fa_s[gi] = bus.a[gi] ^ bus.b[gi] ^ op3[gi];
    assign fa_c[gi] = (bus.a[gi] & bus.b[gi]) | (bus.a[gi] & op3[gi]) | (bus.b[gi] & op3[gi]);
  end

  assign s_chunk   = s_q[k_q*CHUNK +: CHUNK];
  assign c_chunk   = c_q[k_q*CHUNK +: CHUNK];
  assign chunk_res = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cin_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    k_d     = k_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    acc_d   = bus.acc_clr ? '0 : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = fa_s;
          c_d     = {fa_c, 1'b0};
          k_d     = '0;
          cin_d   = 1'b0;
          state_d = PROP;
        end
      end
      PROP: begin
        sum_d[k_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        cin_d = chunk_res[CHUNK];
        if (k_q == KW'(NCHUNK - 1)) begin
          // Top carry-save carry bit plus the ripple carry out of the last chunk.
          carry_d = {1'b0, c_q[WIDTH]} + {1'b0, chunk_res[CHUNK]};
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_d   = sum_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      k_q     <= k_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;

endmodule
